cordic_sweep_sequencer: RTL and testbench

Parametrised angle-sweep sequencer that drives the CORDIC core. It generates the signed input angle X_reg and issues a one-cycle start pulse (cordic_rst). It waits for the core's done, then publishes a qualified sample and advances the angle. It supports configurable width, range, step and four sweep modes, plus done-edge qualification and a timeout/retry watchdog. It sits between the DAC-clock domain control and the CORDIC instance.

---
 rtl/cordic_sweep_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_cordic_sweep_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sweep_sequencer.sv
// Angle-sweep sequencer for a CORDIC core: presents X_reg, pulses cordic_rst,
// qualifies done, publishes the converted angle and steps to the next one.
module cordic_sweep_sequencer #(
    parameter int W       = 8,
    parameter int MIN     = -74,
    parameter int MAX     = 127,
    parameter int STEP    = 1,
    parameter int TIMEOUT = 64,
    parameter int TW      = 8
) (
    input  logic                DAC_clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                done,
    output logic                cordic_rst,
    output logic signed [W-1:0] X_reg,
    output logic                sample_valid,
    output logic signed [W-1:0] sample_x,
    output logic                sweep_done,
    output logic                timeout_err,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Two guard bits keep X +/- STEP exact for any legal STEP up to MAX-MIN.
    localparam int XW = W + 2;
    localparam logic signed [XW-1:0] MIN_E  = XW'(MIN);
    localparam logic signed [XW-1:0] MAX_E  = XW'(MAX);
    localparam logic signed [XW-1:0] STEP_E = XW'(STEP);
    localparam logic [1:0] MODE_WRAP   = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_SINGLE = 2'd2;
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    state_t                state_r;
    state_t                state_s;
    logic                  dir_r;
    logic [TW-1:0]         timer_r;
    logic                  armed_r;
    logic signed [XW-1:0]  x_ext_s;
    logic signed [XW-1:0]  x_up_s;
    logic signed [XW-1:0]  x_dn_s;
    logic signed [W-1:0]   next_x_s;
    logic                  next_dir_s;
    logic                  finish_s;
    logic                  accept_s;
    logic                  timeout_hit_s;

    assign x_ext_s = {{2{X_reg[W-1]}}, X_reg};
    assign x_up_s  = x_ext_s + STEP_E;
    assign x_dn_s  = x_ext_s - STEP_E;
    assign busy    = (state_r != IDLE);

    // done only counts once it has been seen low after the start pulse.
    assign accept_s      = (state_r == WAIT) && armed_r && done;
    assign timeout_hit_s = (TIMEOUT != 0) && (state_r == WAIT) &&
                           (timer_r == TW'(TIMEOUT - 1)) && !accept_s;

    // Next-angle selection for the mode sampled at the accepting edge.
    always_comb begin
        next_x_s   = X_reg;
        next_dir_s = dir_r;
        finish_s   = 1'b0;
        case (mode)
            MODE_WRAP: begin
                if (x_up_s > MAX_E) begin
                    next_x_s = MIN_E[W-1:0];
                end else begin
                    next_x_s = x_up_s[W-1:0];
                end
            end
            MODE_BOUNCE: begin
                if (dir_r == DIR_UP) begin
                    if (x_up_s > MAX_E) begin
                        next_dir_s = DIR_DOWN;
                        next_x_s   = x_dn_s[W-1:0];
                    end else begin
                        next_x_s   = x_up_s[W-1:0];
                    end
                end else begin
                    if (x_dn_s < MIN_E) begin
                        next_dir_s = DIR_UP;
                        next_x_s   = x_up_s[W-1:0];
                    end else begin
                        next_x_s   = x_dn_s[W-1:0];
                    end
                end
            end
            MODE_SINGLE: begin
                if (x_up_s > MAX_E) begin
                    finish_s = 1'b1;
                end else begin
                    next_x_s = x_up_s[W-1:0];
                end
            end
            default: begin
                next_x_s = X_reg;
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (en && !sweep_done) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                state_s = WAIT;
            end
            WAIT: begin
                if (accept_s) begin
                    if (en && !finish_s) begin
                        state_s = START;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (timeout_hit_s) begin
                    state_s = START;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge DAC_clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: angle, direction, watchdog, handshake and published sample.
    always_ff @(posedge DAC_clk) begin
        if (!rst_n) begin
            X_reg        <= MIN_E[W-1:0];
            dir_r        <= DIR_UP;
            cordic_rst   <= 1'b0;
            sample_valid <= 1'b0;
            sample_x     <= {W{1'b0}};
            sweep_done   <= 1'b0;
            timeout_err  <= 1'b0;
            timer_r      <= {TW{1'b0}};
            armed_r      <= 1'b0;
        end else begin
            cordic_rst   <= (state_r == START);
            sample_valid <= accept_s;
            case (state_r)
                IDLE: begin
                    if (!en) begin
                        sweep_done <= 1'b0;
                        X_reg      <= MIN_E[W-1:0];
                        dir_r      <= DIR_UP;
                    end
                end
                START: begin
                    timer_r <= {TW{1'b0}};
                    armed_r <= 1'b0;
                end
                WAIT: begin
                    timer_r <= timer_r + TW'(1);
                    if (!done) begin
                        armed_r <= 1'b1;
                    end
                    if (accept_s) begin
                        sample_x <= X_reg;
                        X_reg    <= next_x_s;
                        dir_r    <= next_dir_s;
                        if (finish_s) begin
                            sweep_done <= 1'b1;
                        end
                    end
                    if (timeout_hit_s) begin
                        timeout_err <= 1'b1;
                    end
                end
                default: begin
                    armed_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sweep_sequencer.sv
// Directed bench for cordic_sweep_sequencer: a CORDIC stand-in answers each
// start pulse, and expected angles are queued and matched on sample_valid.
module tb_cordic_sweep_sequencer;

    logic DAC_clk = 1'b0;
    always #5 DAC_clk = ~DAC_clk;

    logic       rst_n;
    logic       en_a;
    logic       en_b;
    logic       done;
    logic [1:0] mode;
    bit         sel;

    logic              cr_a, sv_a, sd_a, te_a, busy_a;
    logic              cr_b, sv_b, sd_b, te_b, busy_b;
    logic signed [7:0] x_a, sx_a, x_b, sx_b;

    logic              cr_s, sv_s, sd_s, te_s, busy_s;
    logic signed [7:0] x_s, sx_s;
    assign cr_s   = sel ? cr_b   : cr_a;
    assign sv_s   = sel ? sv_b   : sv_a;
    assign sd_s   = sel ? sd_b   : sd_a;
    assign te_s   = sel ? te_b   : te_a;
    assign busy_s = sel ? busy_b : busy_a;
    assign x_s    = sel ? x_b    : x_a;
    assign sx_s   = sel ? sx_b   : sx_a;

    cordic_sweep_sequencer #(.TIMEOUT(16)) dut_a (
        .DAC_clk(DAC_clk), .rst_n(rst_n), .en(en_a), .mode(mode), .done(done),
        .cordic_rst(cr_a), .X_reg(x_a), .sample_valid(sv_a), .sample_x(sx_a),
        .sweep_done(sd_a), .timeout_err(te_a), .busy(busy_a)
    );

    cordic_sweep_sequencer #(.STEP(16), .TIMEOUT(0)) dut_b (
        .DAC_clk(DAC_clk), .rst_n(rst_n), .en(en_b), .mode(mode), .done(done),
        .cordic_rst(cr_b), .X_reg(x_b), .sample_valid(sv_b), .sample_x(sx_b),
        .sweep_done(sd_b), .timeout_err(te_b), .busy(busy_b)
    );

    int checks   = 0;
    int failures = 0;
    int n_start  = 0;
    int n_sample = 0;
    logic signed [7:0] exp_q[$];

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge DAC_clk);
        if (cr_s === 1'b1) n_start++;
        if (sv_s === 1'b1) n_sample++;
    endtask

    task automatic wait_start();
        int k;
        k = 0;
        while (cr_s !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check("start_seen", cr_s, 1);
    endtask

    // One conversion: answer the start pulse with done low for 3 cycles then high.
    task automatic convert(input int exp, input bit last);
        int k;
        logic signed [31:0] e32;
        e32 = exp;
        exp_q.push_back(e32[7:0]);
        wait_start();
        check("x_reg", x_s, exp);
        done = 1'b0;
        repeat (3) tick();
        done = 1'b1;
        if (last) begin
            en_a = 1'b0;
            en_b = 1'b0;
        end
        k = 0;
        while (sv_s !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("sample_seen", sv_s, 1);
        if (exp_q.size() > 0) check("sample_x", sx_s, exp_q.pop_front());
        tick();
        check("sv_one_cycle", sv_s, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int s0, s1, cnt, x, dir_up;
        sel = 1'b0; rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; done = 1'b0; mode = 2'd0;
        repeat (2) tick();
        check("rst_cordic_rst", cr_s, 0);
        check("rst_x_reg", x_s, -74);
        check("rst_sample_valid", sv_s, 0);
        check("rst_sample_x", sx_s, 0);
        check("rst_sweep_done", sd_s, 0);
        check("rst_timeout_err", te_s, 0);
        check("rst_busy", busy_s, 0);
        rst_n = 1'b1;
        tick();

        // Wrap sweep: one full period plus the wrap back to MIN.
        s0 = n_start; s1 = n_sample;
        en_a = 1'b1;
        for (int i = 0; i <= 202; i++) begin
            convert((i == 202) ? -74 : (-74 + i), i == 202);
        end
        tick();
        check("wrap_start_count", n_start - s0, 203);
        check("wrap_sample_count", n_sample - s1, 203);
        check("wrap_idle_busy", busy_s, 0);

        // Single-shot sweep, then restart after en seen low.
        mode = 2'd2; en_a = 1'b1;
        for (int i = 0; i <= 201; i++) begin
            convert(-74 + i, 1'b0);
        end
        check("single_sweep_done", sd_s, 1);
        check("single_busy", busy_s, 0);
        s0 = n_start;
        repeat (20) tick();
        check("single_no_restart", n_start - s0, 0);
        en_a = 1'b0;
        tick();
        en_a = 1'b1;
        convert(-74, 1'b0);
        check("single_cleared", sd_s, 0);

        // Watchdog: withhold done, expect a retry of the same angle.
        wait_start();
        check("to_err_before", te_s, 0);
        done = 1'b0;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (cr_s !== 1'b1 && cnt < 40);
        check("retry_period", cnt, 17);
        check("to_err_after", te_s, 1);
        check("retry_x_reg", x_s, -73);
        convert(-73, 1'b0);

        // done stuck high: never accepted, periodic retries.
        mode = 2'd3; done = 1'b1;
        wait_start();
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (cr_s !== 1'b1 && cnt < 40);
        check("stuck_retry_period", cnt, 17);
        s1 = n_sample;
        repeat (40) tick();
        check("stuck_no_sample", n_sample - s1, 0);
        check("stuck_x_reg", x_s, -72);
        check("stuck_to_err", te_s, 1);

        // Reset mid-WAIT with done arriving right after it.
        mode = 2'd0;
        wait_start();
        done = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_cordic_rst", cr_s, 0);
        check("mid_rst_x_reg", x_s, -74);
        check("mid_rst_sample_valid", sv_s, 0);
        check("mid_rst_sample_x", sx_s, 0);
        check("mid_rst_sweep_done", sd_s, 0);
        check("mid_rst_timeout_err", te_s, 0);
        check("mid_rst_busy", busy_s, 0);
        rst_n = 1'b1; done = 1'b1;
        s1 = n_sample;
        tick();
        convert(-74, 1'b1);
        check("post_rst_one_sample", n_sample - s1, 1);
        repeat (4) tick();

        // Bounce sweep on the STEP=16 instance.
        sel = 1'b1; mode = 2'd1; en_b = 1'b1;
        x = -74; dir_up = 1;
        for (int i = 0; i < 26; i++) begin
            convert(x, i == 25);
            if (dir_up == 1) begin
                if (x + 16 > 127) begin dir_up = 0; x = x - 16; end
                else x = x + 16;
            end else begin
                if (x - 16 < -74) begin dir_up = 1; x = x + 16; end
                else x = x + -16;
            end
        end
        check("bounce_no_timeout", te_s, 0);
        check("bounce_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
